// File: rtl/vending_pkg.sv
// Shared vending-machine definitions: payout FSM states, coin values and drink price.
package vending_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CHOOSE     = 3'd1,
    ST_DRIVE_ONE  = 3'd2,
    ST_DRIVE_HALF = 3'd3,
    ST_GAP        = 3'd4,
    ST_DONE       = 3'd5,
    ST_FAULT      = 3'd6
  } state_e;

  // Coin values and prices are expressed in 5-jiao units.
  localparam int unsigned COIN_ONE  = 2;
  localparam int unsigned COIN_HALF = 1;
  localparam int unsigned PRICE     = 5;

endpackage

// File: rtl/dispense_timer.sv
// Hopper timeout counter: counts enabled cycles and flags the last permitted cycle.
module dispense_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturate at LAST so a stalled FSM can never wrap the count.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/change_dispenser.sv
// Coin payout controller: pays a 5-jiao-unit amount through 1-yuan and 5-jiao hoppers,
// one coin per enable/ack handshake, with empty-hopper fallback and hopper timeout.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int unsigned AMT_W   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [AMT_W-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [AMT_W-1:0] paid,
  output logic             one_en,
  input  logic             one_ack,
  input  logic             one_empty,
  output logic             half_en,
  input  logic             half_ack,
  input  logic             half_empty
);

  localparam logic [AMT_W-1:0] ONE_V  = AMT_W'(COIN_ONE);
  localparam logic [AMT_W-1:0] HALF_V = AMT_W'(COIN_HALF);

  state_e           state_q, state_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic [AMT_W-1:0] paid_q, paid_d;
  logic             fault_q, fault_d;
  logic             in_drive;
  logic             expired;

  assign in_drive = (state_q == ST_DRIVE_ONE) || (state_q == ST_DRIVE_HALF);

  // One counter serves both hoppers; it is held clear outside the drive states.
  dispense_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (!in_drive),
    .enable  (in_drive),
    .expired (expired)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    paid_d      = paid_q;
    fault_d     = fault_q;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          remaining_d = amount;
          paid_d      = '0;
          fault_d     = 1'b0;
          state_d     = (amount == '0) ? ST_DONE : ST_CHOOSE;
        end
      end

      // Largest coin first; never pick a coin larger than what is still owed.
      ST_CHOOSE: begin
        if ((remaining_q >= ONE_V) && !one_empty) begin
          state_d = ST_DRIVE_ONE;
        end else if ((remaining_q >= HALF_V) && !half_empty) begin
          state_d = ST_DRIVE_HALF;
        end else begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end
      end

      ST_DRIVE_ONE: begin
        if (one_ack) begin
          remaining_d = remaining_q - ONE_V;
          paid_d      = paid_q + ONE_V;
          state_d     = ST_GAP;
        end else if (expired) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end
      end

      ST_DRIVE_HALF: begin
        if (half_ack) begin
          remaining_d = remaining_q - HALF_V;
          paid_d      = paid_q + HALF_V;
          state_d     = ST_GAP;
        end else if (expired) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end
      end

      ST_GAP:   state_d = (remaining_q == '0) ? ST_DONE : ST_CHOOSE;
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      paid_q      <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      paid_q      <= paid_d;
      fault_q     <= fault_d;
    end
  end

  // Strobes are decoded from the state register so reset drops them immediately.
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign one_en  = (state_q == ST_DRIVE_ONE);
  assign half_en = (state_q == ST_DRIVE_HALF);
  assign fault   = fault_q;
  assign paid    = paid_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed and random payouts against a transaction-level model.
module tb_change_dispenser;

  localparam int unsigned AMT_W   = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam int          BUDGET  = 600;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             req = 1'b0;
  logic [AMT_W-1:0] amount = '0;
  logic             busy, done, fault, one_en, half_en;
  logic [AMT_W-1:0] paid;
  logic             one_ack = 1'b0, one_empty = 1'b0;
  logic             half_ack = 1'b0, half_empty = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_one[$], exp_half[$], act_one[$], act_half[$];

  change_dispenser #(
    .AMT_W   (AMT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .amount     (amount),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .paid       (paid),
    .one_en     (one_en),
    .one_ack    (one_ack),
    .one_empty  (one_empty),
    .half_en    (half_en),
    .half_ack   (half_ack),
    .half_empty (half_empty)
  );

  always #5 clk = ~clk;

  // One payout. Delay d>0 means ack is raised in the d-th cycle the enable is high;
  // d==0 means that hopper never acks.
  task automatic run_txn(input logic [AMT_W-1:0] amt, input logic oe, input logic he,
                         input int od, input int hd, input bit stray, input bit req_noise,
                         input string name);
    int rem, epaid, ebusy, val, dly, len;
    bit efault, edone, tmo, isone, fin;
    int busy_cnt, done_cnt, both_cnt, one_run, half_run;

    exp_one.delete(); exp_half.delete(); act_one.delete(); act_half.delete();
    rem = int'(amt); epaid = 0; ebusy = 0; efault = 1'b0; edone = 1'b0; fin = 1'b0;
    if (rem == 0) begin
      ebusy = 1; edone = 1'b1; fin = 1'b1;
    end
    for (int g = 0; g < 64 && !fin; g++) begin
      ebusy++;
      if (rem >= 2 && !oe) begin
        val = 2; dly = od; isone = 1'b1;
      end else if (rem >= 1 && !he) begin
        val = 1; dly = hd; isone = 1'b0;
      end else begin
        ebusy++; efault = 1'b1; fin = 1'b1;
        break;
      end
      tmo = (dly == 0) || (dly > int'(TIMEOUT));
      len = tmo ? int'(TIMEOUT) : dly;
      if (isone) exp_one.push_back(len); else exp_half.push_back(len);
      ebusy += len;
      if (tmo) begin
        ebusy++; efault = 1'b1; fin = 1'b1;
        break;
      end
      epaid += val; rem -= val; ebusy++;
      if (rem == 0) begin
        ebusy++; edone = 1'b1; fin = 1'b1;
      end
    end

    @(negedge clk);
    one_empty = oe; half_empty = he; amount = amt; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    amount = AMT_W'($urandom);
    busy_cnt = 0; done_cnt = 0; both_cnt = 0; one_run = 0; half_run = 0;
    for (int c = 0; c < BUDGET; c++) begin
      if (busy !== 1'b1) break;
      busy_cnt++;
      if (done === 1'b1) done_cnt++;
      if (one_en === 1'b1 && half_en === 1'b1) both_cnt++;
      if (one_en === 1'b1) one_run++;
      else if (one_run != 0) begin act_one.push_back(one_run); one_run = 0; end
      if (half_en === 1'b1) half_run++;
      else if (half_run != 0) begin act_half.push_back(half_run); half_run = 0; end
      one_ack  = (one_en === 1'b1 && one_run == od) || (stray && half_en === 1'b1);
      half_ack = (half_en === 1'b1 && half_run == hd) || (stray && one_en === 1'b1);
      req      = req_noise && ($urandom_range(0, 1) == 1);
      amount   = AMT_W'($urandom);
      @(negedge clk);
    end
    one_ack = 1'b0; half_ack = 1'b0; req = 1'b0;

    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL %s completion: busy=%b still high after %0d cycles, required 0", name, busy, BUDGET);
    end
    n_checks++;
    if (busy_cnt !== ebusy) begin
      n_fail++; $display("FAIL %s busy_cycles: got %0d, expected %0d", name, busy_cnt, ebusy);
    end
    n_checks++;
    if (paid !== AMT_W'(epaid)) begin
      n_fail++; $display("FAIL %s paid: got %0d, expected %0d", name, paid, epaid);
    end
    n_checks++;
    if (fault !== efault) begin
      n_fail++; $display("FAIL %s fault: got %b, expected %b", name, fault, efault);
    end
    n_checks++;
    if (done_cnt !== int'(edone)) begin
      n_fail++; $display("FAIL %s done_pulses: got %0d, expected %0d", name, done_cnt, edone);
    end
    n_checks++;
    if (both_cnt !== 0) begin
      n_fail++; $display("FAIL %s both_enables: got %0d overlap cycles, expected 0", name, both_cnt);
    end
    n_checks++;
    if (act_one.size() !== exp_one.size()) begin
      n_fail++; $display("FAIL %s one_pulses: got %0d, expected %0d", name, act_one.size(), exp_one.size());
    end
    n_checks++;
    if (act_half.size() !== exp_half.size()) begin
      n_fail++; $display("FAIL %s half_pulses: got %0d, expected %0d", name, act_half.size(), exp_half.size());
    end
    for (int i = 0; i < act_one.size() && i < exp_one.size(); i++) begin
      n_checks++;
      if (act_one[i] !== exp_one[i]) begin
        n_fail++; $display("FAIL %s one_len[%0d]: got %0d, expected %0d", name, i, act_one[i], exp_one[i]);
      end
    end
    for (int i = 0; i < act_half.size() && i < exp_half.size(); i++) begin
      n_checks++;
      if (act_half[i] !== exp_half[i]) begin
        n_fail++; $display("FAIL %s half_len[%0d]: got %0d, expected %0d", name, i, act_half[i], exp_half[i]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, fault, one_en, half_en} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b, expected 00000", {busy, done, fault, one_en, half_en});
    end
    n_checks++;
    if (paid !== '0) begin
      n_fail++; $display("FAIL reset_paid: got %0d, expected 0", paid);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, fault, one_en, half_en} !== 5'b0) begin
      n_fail++; $display("FAIL post_reset_flags: got %b, expected 00000", {busy, done, fault, one_en, half_en});
    end
  endtask

  task automatic test_directed();
    run_txn(4'd3, 1'b0, 1'b0, 3, 3, 1'b0, 1'b0, "amt3_full");
    run_txn(4'd4, 1'b1, 1'b0, 3, 3, 1'b0, 1'b0, "halves_only");
    run_txn(4'd3, 1'b0, 1'b1, 3, 3, 1'b0, 1'b0, "half_empty_fault");
    run_txn(4'd0, 1'b0, 1'b0, 1, 1, 1'b0, 1'b0, "zero_clears_fault");
    run_txn(4'd2, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0, "one_timeout");
    run_txn(4'd2, 1'b0, 1'b0, int'(TIMEOUT), 1, 1'b0, 1'b0, "ack_at_expiry");
    run_txn(4'd1, 1'b1, 1'b1, 1, 1, 1'b0, 1'b0, "both_empty");
    run_txn(4'd15, 1'b0, 1'b0, 1, 1, 1'b0, 1'b0, "max_amount");
  endtask

  task automatic test_back_to_back();
    run_txn(4'd5, 1'b0, 1'b0, 2, 2, 1'b1, 1'b1, "busy_req_stray_ack");
    run_txn(4'd7, 1'b0, 1'b0, 1, 2, 1'b1, 1'b1, "busy_req_stray_ack2");
  endtask

  task automatic test_reset_mid();
    bit reached;
    reached = 1'b0;
    @(negedge clk);
    one_empty = 1'b0; half_empty = 1'b0; amount = 4'd3; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (half_en === 1'b1) begin reached = 1'b1; break; end
      one_ack = (one_en === 1'b1);
      @(negedge clk);
    end
    one_ack = 1'b0;
    n_checks++;
    if (!reached) begin
      n_fail++; $display("FAIL mid_reset_reach_half: half_en=%b, expected 1", half_en);
    end
    n_checks++;
    if (paid !== 4'd2) begin
      n_fail++; $display("FAIL mid_reset_paid_before: got %0d, expected 2", paid);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, fault, one_en, half_en} !== 5'b0) begin
      n_fail++; $display("FAIL mid_reset_async_flags: got %b, expected 00000", {busy, done, fault, one_en, half_en});
    end
    n_checks++;
    if (paid !== '0) begin
      n_fail++; $display("FAIL mid_reset_async_paid: got %0d, expected 0", paid);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_txn(4'd1, 1'b0, 1'b0, 2, 2, 1'b0, 1'b0, "after_mid_reset");
  endtask

  function automatic int pick_delay();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 7) return int'($urandom_range(1, 4));
    if (r == 7) return int'(TIMEOUT);
    if (r == 8) return 0;
    return int'(TIMEOUT) + 1;
  endfunction

  task automatic test_random();
    logic [AMT_W-1:0] amt;
    logic oe, he;
    int od, hd;
    bit stray, rn;
    for (int i = 0; i < 40; i++) begin
      amt   = AMT_W'($urandom_range(0, 15));
      oe    = ($urandom_range(0, 3) == 0);
      he    = ($urandom_range(0, 3) == 0);
      od    = pick_delay();
      hd    = pick_delay();
      stray = ($urandom_range(0, 1) == 1);
      rn    = ($urandom_range(0, 1) == 1);
      run_txn(amt, oe, he, od, hd, stray, rn, $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Coin payout controller for the drink vending machine. It takes a change or refund amount in 5-jiao units from the sales FSM and pays it out through two coin hoppers (1-yuan and 5-jiao), one coin at a time, using a per-coin enable/acknowledge handshake. Where the sales FSM flags that change is owed, this block actually pays it. It also handles the empty-hopper fallback and hopper timeouts.

## Interface
Parameters:
- AMT_W, 4, width of amount and paid, in 5-jiao units (max 7.5 yuan)
- TIMEOUT, 16, maximum cycles hopper enable stays high without an ack before fault

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req  in  1  payout request, sampled only in IDLE
- amount  in  AMT_W  amount to pay in 5-jiao units, sampled with req
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a payout completes successfully
- fault  out  1  sticky error flag; cleared by the next accepted req
- paid  out  AMT_W  5-jiao units dispensed in the current or last transaction
- one_en  out  1  drive 1-yuan hopper; held high until one_ack or timeout
- one_ack  in  1  1-yuan coin ejected
- one_empty  in  1  1-yuan hopper empty
- half_en  out  1  drive 5-jiao hopper; held high until half_ack or timeout
- half_ack  in  1  5-jiao coin ejected
- half_empty  in  1  5-jiao hopper empty

## Operation
- States: IDLE, CHOOSE, DRIVE_ONE, DRIVE_HALF, GAP, DONE, FAULT.
- **IDLE**
  - On req: latch remaining=amount, clear paid and fault.
  - amount==0 goes to DONE (no coins paid). Otherwise go to CHOOSE.
- **CHOOSE** (coin selection, in priority order)
  - remaining>=2 and !one_empty: DRIVE_ONE.
  - Else remaining>=1 and !half_empty: DRIVE_HALF. This covers 1 yuan paid as two 5-jiao coins when the 1-yuan hopper is empty.
  - Else FAULT. The block never overpays.
- **DRIVE_x**
  - x_en=1. Timeout counter is cleared on entry.
  - On x_ack: remaining -= value (2 for 1-yuan, 1 for 5-jiao), paid += value, go to GAP.
  - If there is no ack and the counter reaches TIMEOUT-1: go to FAULT.
  - Ack in the expiry cycle wins.
- **GAP**: both enables low for exactly one cycle. Then remaining==0 goes to DONE, else CHOOSE.
- **DONE**: done=1 for one cycle, then IDLE.
- **FAULT**: set fault, then IDLE. paid holds the partial amount.
- Other rules:
  - req while busy is ignored.
  - Acks outside the matching DRIVE state are ignored.
  - Empty flags are sampled only in CHOOSE.
  - Arithmetic: remaining and paid are AMT_W unsigned. Subtraction cannot underflow because of the CHOOSE guards. paid never exceeds amount.
- Reset mid-payout: everything returns to reset values at once and the hopper enables drop immediately. The unpaid remainder is lost.

## Timing
- Reset values:
  - state=IDLE.
  - busy, done, fault, one_en, half_en, paid, remaining, timeout counter are all 0.
- All outputs are registered or decoded from the registered state; none is combinational from inputs.
- req sampled at edge k:
  - busy=1 from k+1 (CHOOSE).
  - Enable high from k+2.
- Ack sampled at edge m:
  - Enable low from m+1 (GAP).
  - Next enable at m+3 at the earliest.
- Minimum 3 cycles per coin.
- Zero-amount req at k: done pulse in the cycle after k+1, busy=0 again from k+2.
- Hopper without ack: enable high for exactly TIMEOUT cycles, fault=1 the next cycle.
- Success path: done asserted the cycle after the last GAP; busy falls with done deasserting.

## Structure
- Shared package (vending_pkg):
  - State encoding constants.
  - Coin value constants: COIN_ONE=2, COIN_HALF=1.
  - Drink price constant: PRICE=5, in 5-jiao units.
- One sub-module, dispense_timer, with ports clear, enable, expired; parameter TIMEOUT. It is the timeout counter, instantiated once and shared by both DRIVE states.
- Datapath (remaining, paid) and the FSM stay in change_dispenser.

## Test plan
- **req, amount=3, both hoppers full, acks 2 cycles after enable**: one_en pulse then half_en pulse, paid=3, one done pulse, fault=0.
- **amount=4, one_empty=1 throughout**: four half_en handshakes, paid=4, done.
- **amount=3, half_empty=1**: one 1-yuan coin, then FAULT with paid=2, fault=1, no done. The next req with amount=0 clears fault.
- **amount=2, one_ack never asserted**: one_en high exactly 16 cycles, then fault=1, paid=0. Ack at cycle 16 instead: success, no fault.
- **req pulsed again while busy, and stray half_ack during DRIVE_ONE**: both ignored, payout unchanged.
- **reset asserted during DRIVE_HALF**: half_en drops asynchronously, all outputs 0; after release, a new req with amount=1 completes normally.
